// File: rtl/alu_fib_pkg.sv
// Shared types and constants for the button-stepped Fibonacci controller.
package alu_fib_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WB   = 3'd2,
    RUN  = 3'd3,
    HALT = 3'd4
  } state_t;

  // ALU opcodes; the controller only ever issues ALU_ADD
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Flag bit positions: f[0] zero, f[1] carry/borrow, f[2] negative (result msb)
  localparam int FLAG_W = 3;
  localparam int F_ZERO = 0;
  localparam int F_CRY  = 1;
  localparam int F_NEG  = 2;

endpackage

// File: rtl/alu.sv
// Small combinational ALU: WIDTH-bit result plus zero/carry/negative flags.
module alu
  import alu_fib_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [2:0]        s_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [WIDTH-1:0]  y_o,
  output logic [FLAG_W-1:0] f_o
);

  logic [WIDTH:0] wide;

  // Compute the result one bit wider so the carry/borrow falls out of the msb
  always_comb begin
    wide = '0;
    case (s_i)
      ALU_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: wide = {1'b0, a_i} - {1'b0, b_i};
      ALU_AND: wide = {1'b0, a_i & b_i};
      ALU_OR:  wide = {1'b0, a_i | b_i};
      ALU_XOR: wide = {1'b0, a_i ^ b_i};
      default: wide = {1'b0, a_i};
    endcase
  end

  assign y_o           = wide[WIDTH-1:0];
  assign f_o[F_ZERO]   = (wide[WIDTH-1:0] == '0);
  assign f_o[F_CRY]    = wide[WIDTH];
  assign f_o[F_NEG]    = wide[WIDTH-1];

endmodule

// File: rtl/debounce_pulse.sv
// Two-flop synchroniser, stability-window debouncer and rising-edge pulse.
module debounce_pulse #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  // Accept a new level only after DB_CYCLES consecutive samples that differ
  // from the current accepted level; any agreeing sample restarts the window.
  // Reset puts everything at the released level so reset exit never fires.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
        pulse_q  <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_fib_ctrl.sv
// Button-stepped Fibonacci generator: each debounced press adds the two
// newest terms through the shared ALU and shows the result on the LEDs.
module alu_fib_ctrl
  import alu_fib_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        BTNC,
  input  logic [15:0] SW,
  output logic [15:0] LED
);

  state_t             state_q;
  logic [WIDTH-1:0]   r0_q, r1_q, sum_q, term_q;
  logic [FLAG_W-1:0]  flg_q, lflg_q;
  logic [3:0]         cnt_q, cnt_d;
  logic               halt_q;
  logic               step_pulse;
  logic [WIDTH-1:0]   alu_y;
  logic [FLAG_W-1:0]  alu_f;
  logic               sw_unused;

  assign sw_unused = ^SW[15:12];

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn_i     (BTNC),
    .pulse_o   (step_pulse)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .s_i(ALU_ADD),
    .a_i(r0_q),
    .b_i(r1_q),
    .y_o(alu_y),
    .f_o(alu_f)
  );

  // Step counter saturates so long zero-seed runs stay at 15
  assign cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  // Controller: pulses are only acted on in IDLE and RUN, so presses during
  // CALC/WB are dropped and HALT is left only through reset
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      sum_q   <= '0;
      flg_q   <= '0;
      term_q  <= '0;
      lflg_q  <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (step_pulse) begin
          r0_q    <= WIDTH'(SW[5:0]);
          r1_q    <= WIDTH'(SW[11:6]);
          term_q  <= WIDTH'(SW[11:6]);
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: if (step_pulse) state_q <= CALC;
        CALC: begin
          sum_q   <= alu_y;
          flg_q   <= alu_f;
          state_q <= WB;
        end
        WB: begin
          lflg_q <= flg_q;
          if (!flg_q[F_CRY]) begin
            r0_q    <= r1_q;
            r1_q    <= sum_q;
            term_q  <= sum_q;
            cnt_q   <= cnt_d;
            state_q <= RUN;
          end else begin
            halt_q  <= 1'b1;
            state_q <= HALT;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LED = {lflg_q, halt_q, cnt_q, 2'b00, 6'(term_q)};

endmodule

// File: tb/tb_alu_fib_ctrl.sv
// Directed + randomized bench for alu_fib_ctrl with a term/step-level model.
module tb_alu_fib_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        btn, btn2;
  logic [15:0] sw, sw2;
  logic [15:0] led, led2;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the last two terms, shown term, step count, flags
  bit m_idle, m_halt;
  int m_f0, m_f1, m_term, m_cnt, m_flg;

  always #5 clk = ~clk;

  alu_fib_ctrl #(.WIDTH(6), .DB_CYCLES(4)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .BTNC(btn), .SW(sw), .LED(led)
  );

  // Short-window instance so two accepted edges can land inside one step
  alu_fib_ctrl #(.WIDTH(6), .DB_CYCLES(1)) dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .BTNC(btn2), .SW(sw2), .LED(led2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_led();
    return {3'(m_flg), m_halt, 4'(m_cnt), 2'b00, 6'(m_term)};
  endfunction

  task automatic model_reset();
    m_idle = 1; m_halt = 0;
    m_f0 = 0; m_f1 = 0; m_term = 0; m_cnt = 0; m_flg = 0;
  endtask

  // One accepted press, in Fibonacci terms
  task automatic model_step();
    int s, y, c;
    if (m_idle) begin
      m_f0 = int'(sw[5:0]); m_f1 = int'(sw[11:6]);
      m_term = m_f1; m_cnt = 0; m_idle = 0;
    end else if (!m_halt) begin
      s = m_f0 + m_f1;
      y = s % 64;
      c = (s >= 64) ? 1 : 0;
      m_flg = ((y >= 32) ? 4 : 0) + c * 2 + ((y == 0) ? 1 : 0);
      if (c == 1) m_halt = 1;
      else begin
        m_f0 = m_f1; m_f1 = y; m_term = y;
        m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      end
    end
  endtask

  // Clean press with a latency check: LED must be unchanged at the end of
  // cycle n+1 after the pulse and updated by the end of cycle n+2
  task automatic press();
    logic [15:0] old;
    bit was_idle;
    int n;
    old = exp_led();
    was_idle = m_idle;
    btn = 1'b1;
    n = 0;
    while (dut.step_pulse !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", {15'b0, dut.step_pulse}, 16'd1);
    model_step();
    @(negedge clk);
    @(negedge clk);
    if (!was_idle) chk("latency_hold", led, old);
    @(negedge clk);
    chk("step_led", led, exp_led());
    btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("settled_led", led, exp_led());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    btn = 1'b0;
    btn2 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_led", led, 16'h0000);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit [15:0] bounce;
    rstn = 1'b0; btn = 1'b0; btn2 = 1'b0; sw = '0; sw2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_led", led, 16'h0000);
    chk("reset_led2", led2, 16'h0000);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Seeds 1,1: load, then eight steps up to 55
    sw = {4'h0, 6'd1, 6'd1};
    press();
    chk("load_term", {10'b0, led[5:0]}, 16'd1);
    repeat (8) press();
    chk("fib_term55", {10'b0, led[5:0]}, 16'd55);
    chk("fib_cnt8", {12'b0, led[11:8]}, 16'd8);
    press();
    chk("halt_term", {10'b0, led[5:0]}, 16'd55);
    chk("halt_bits", {14'b0, led[14], led[12]}, 16'b11);
    press();
    chk("halt_ignore", led, 16'h5837);

    // Reset while a step is in flight, then confirm IDLE by reloading seeds
    do_reset();
    sw = {4'h0, 6'd7, 6'd2};
    press();
    press();
    btn = 1'b1;
    for (int i = 0; i < 40 && dut.step_pulse !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrun_reset", led, 16'h0000);
    btn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_release_pulse", led, 16'h0000);
    press();
    chk("reload_after_reset", led, 16'h0007);

    // Bouncy press: 3-cycle glitches must not count, then one stable press
    bounce = 16'b0000_0111_0001_1100;
    for (int i = 0; i < 16; i++) begin
      btn = bounce[i];
      @(negedge clk);
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    model_step();
    repeat (16) @(negedge clk);
    chk("bounce_one_step", led, exp_led());

    // Zero seeds: twenty presses keep the term at 0, count saturates
    do_reset();
    sw = 16'h0000;
    repeat (20) press();
    chk("zero_seeds", {led[12], 3'b0, led[11:8], 2'b0, led[5:0]}, 16'h0F00);

    // Second pulse two cycles after the first lands mid-step and is dropped
    sw2 = {4'h0, 6'd5, 6'd3};
    btn2 = 1'b1;
    repeat (2) @(negedge clk);
    btn2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("dut2_load", led2, 16'h0005);
    btn2 = 1'b1; @(negedge clk);
    btn2 = 1'b0; @(negedge clk);
    btn2 = 1'b1; @(negedge clk);
    btn2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_midstep", led2, 16'h0108);
    btn2 = 1'b1; @(negedge clk);
    btn2 = 1'b0; @(negedge clk);
    btn2 = 1'b1; @(negedge clk);
    btn2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_midstep2", led2, 16'h020D);

    // Random seeds (unused switch bits randomized too)
    for (int r = 0; r < 4; r++) begin
      do_reset();
      sw = 16'($urandom);
      repeat (12) press();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
